// File: rtl/ip_rx_hdr_check.sv
// IPv4 receive header checker: sums and validates the header, latches key fields and forwards
// exactly the payload bytes. Define IP_RX_DST_FILTER_EN to add destination address filtering.
module ip_rx_hdr_check #(
  parameter logic [31:0] LOCAL_IP = 32'hC0A80002
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_in_data,
  input  logic        i_in_valid,
  input  logic        i_in_sof,
  input  logic        i_in_eof,
  output logic        o_hdr_done,
  output logic        o_hdr_ok,
  output logic        o_err_csum,
  output logic        o_err_fmt,
  output logic        o_err_short,
`ifdef IP_RX_DST_FILTER_EN
  output logic        o_err_dst,
`endif
  output logic [31:0] o_ip_src,
  output logic [31:0] o_ip_dst,
  output logic [7:0]  o_ip_proto,
  output logic [15:0] o_ip_id,
  output logic [15:0] o_ip_len,
  output logic [7:0]  o_pay_data,
  output logic        o_pay_valid,
  output logic        o_pay_last,
  output logic        o_pay_trunc
);

  typedef enum logic [1:0] {StIdle, StHdr, StPay, StDrop} state_e;

  state_e      r_state, w_state_nxt;
  logic [5:0]  r_byte_cnt;
  logic [20:0] r_acc;
  logic [7:0]  r_hi;
  logic [7:0]  r_ver_ihl;
  logic [15:0] r_pay_cnt;

  logic        w_start, w_hdr_byte, w_pay_byte;
  logic        w_vfmt_bad, w_len_bad, w_fmt_bad;
  logic [5:0]  w_hdr_len;
  logic        w_hdr_end, w_short;
  logic [20:0] w_acc_sum;
  logic [16:0] w_f1;
  logic [15:0] w_f2;
  logic        w_pass, w_dst_ok, w_ok;
  logic [15:0] w_pay_len;
  logic        w_pay_end;

  assign w_start    = i_in_valid & i_in_sof;
  assign w_hdr_byte = i_in_valid & ~i_in_sof & (r_state == StHdr);
  assign w_pay_byte = i_in_valid & ~i_in_sof & (r_state == StPay);

  // A malformed version/IHL still consumes a minimal 20-byte header before the verdict.
  assign w_vfmt_bad = (r_ver_ihl[7:4] != 4'd4) | (r_ver_ihl[3:0] < 4'd5);
  assign w_hdr_len  = w_vfmt_bad ? 6'd20 : {r_ver_ihl[3:0], 2'b00};
  assign w_len_bad  = r_ip_len_lt();
  assign w_fmt_bad  = w_vfmt_bad | w_len_bad;
  assign w_pay_len  = o_ip_len - {10'd0, w_hdr_len};

  function automatic logic r_ip_len_lt();
    return o_ip_len < {10'd0, w_hdr_len};
  endfunction

  assign w_hdr_end = w_hdr_byte & (r_byte_cnt == w_hdr_len - 6'd1);
  assign w_short   = w_hdr_byte & i_in_eof & ~w_hdr_end;

  assign w_acc_sum = r_acc + {5'd0, r_hi, i_in_data};
  assign w_f1      = {1'b0, w_acc_sum[15:0]} + {12'd0, w_acc_sum[20:16]};
  assign w_f2      = w_f1[15:0] + {15'd0, w_f1[16]};
  assign w_pass    = (w_f2 == 16'hFFFF);

`ifdef IP_RX_DST_FILTER_EN
  logic [31:0] w_dst_full;
  // The last destination byte may arrive on the header-end cycle itself.
  assign w_dst_full = (r_byte_cnt == 6'd19) ? {o_ip_dst[31:8], i_in_data} : o_ip_dst;
  assign w_dst_ok   = (w_dst_full == LOCAL_IP) | (w_dst_full == 32'hFFFF_FFFF);
`else
  logic w_unused_local_ip;
  assign w_unused_local_ip = ^LOCAL_IP;
  assign w_dst_ok          = 1'b1;
`endif

  assign w_ok      = w_pass & ~w_fmt_bad & w_dst_ok;
  assign w_pay_end = (r_pay_cnt == 16'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = StHdr;
    end else begin
      unique case (r_state)
        StIdle: w_state_nxt = StIdle;
        StHdr: begin
          if (w_short) begin
            w_state_nxt = StIdle;
          end else if (w_hdr_end) begin
            if (i_in_eof)                         w_state_nxt = StIdle;
            else if (w_ok && w_pay_len != 16'd0)  w_state_nxt = StPay;
            else                                  w_state_nxt = StDrop;
          end
        end
        StPay: begin
          if (w_pay_byte) begin
            if (w_pay_end)     w_state_nxt = i_in_eof ? StIdle : StDrop;
            else if (i_in_eof) w_state_nxt = StIdle;
          end
        end
        StDrop: begin
          if (i_in_valid && i_in_eof) w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte_cnt  <= '0;
      r_acc       <= '0;
      r_hi        <= '0;
      r_ver_ihl   <= '0;
      r_pay_cnt   <= '0;
      o_hdr_done  <= 1'b0;
      o_hdr_ok    <= 1'b0;
      o_err_csum  <= 1'b0;
      o_err_fmt   <= 1'b0;
      o_err_short <= 1'b0;
`ifdef IP_RX_DST_FILTER_EN
      o_err_dst   <= 1'b0;
`endif
      o_ip_src    <= '0;
      o_ip_dst    <= '0;
      o_ip_proto  <= '0;
      o_ip_id     <= '0;
      o_ip_len    <= '0;
      o_pay_data  <= '0;
      o_pay_valid <= 1'b0;
      o_pay_last  <= 1'b0;
      o_pay_trunc <= 1'b0;
    end else begin
      o_hdr_done  <= 1'b0;
      o_pay_valid <= 1'b0;
      o_pay_last  <= 1'b0;
      o_pay_trunc <= 1'b0;
      if (w_start) begin
        r_byte_cnt <= 6'd1;
        r_acc      <= '0;
        r_hi       <= i_in_data;
        r_ver_ihl  <= i_in_data;
        r_pay_cnt  <= '0;
      end else if (w_hdr_byte) begin
        r_byte_cnt <= r_byte_cnt + 6'd1;
        if (r_byte_cnt[0]) r_acc <= w_acc_sum;
        else               r_hi  <= i_in_data;
        case (r_byte_cnt)
          6'd2:  o_ip_len[15:8]   <= i_in_data;
          6'd3:  o_ip_len[7:0]    <= i_in_data;
          6'd4:  o_ip_id[15:8]    <= i_in_data;
          6'd5:  o_ip_id[7:0]     <= i_in_data;
          6'd9:  o_ip_proto       <= i_in_data;
          6'd12: o_ip_src[31:24]  <= i_in_data;
          6'd13: o_ip_src[23:16]  <= i_in_data;
          6'd14: o_ip_src[15:8]   <= i_in_data;
          6'd15: o_ip_src[7:0]    <= i_in_data;
          6'd16: o_ip_dst[31:24]  <= i_in_data;
          6'd17: o_ip_dst[23:16]  <= i_in_data;
          6'd18: o_ip_dst[15:8]   <= i_in_data;
          6'd19: o_ip_dst[7:0]    <= i_in_data;
          default: ;
        endcase
        if (w_hdr_end) begin
          o_hdr_done  <= 1'b1;
          o_hdr_ok    <= w_ok;
          o_err_csum  <= ~w_pass;
          o_err_fmt   <= w_fmt_bad;
          o_err_short <= 1'b0;
`ifdef IP_RX_DST_FILTER_EN
          o_err_dst   <= ~w_dst_ok;
`endif
          r_pay_cnt   <= w_pay_len;
        end else if (w_short) begin
          o_hdr_done  <= 1'b1;
          o_hdr_ok    <= 1'b0;
          o_err_csum  <= 1'b0;
          o_err_fmt   <= 1'b0;
          o_err_short <= 1'b1;
`ifdef IP_RX_DST_FILTER_EN
          o_err_dst   <= 1'b0;
`endif
        end
      end else if (w_pay_byte) begin
        o_pay_valid <= 1'b1;
        o_pay_data  <= i_in_data;
        r_pay_cnt   <= r_pay_cnt - 16'd1;
        o_pay_last  <= w_pay_end | i_in_eof;
        o_pay_trunc <= i_in_eof & ~w_pay_end;
      end
    end
  end

endmodule
